// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: request fields in, encoded
// instruction words out through a valid/ready register.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        split_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;
  logic        out_last;
  logic [15:0] err_count;

  modport master (
    output in_valid, imm_src, imm, opcode, funct3, rd, rs1, rs2, split_en, out_ready,
    input  in_ready, out_valid, out_word, out_err, out_last, err_count
  );

  modport slave (
    input  in_valid, imm_src, imm, opcode, funct3, rd, rs1, rs2, split_en, out_ready,
    output in_ready, out_valid, out_word, out_err, out_last, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// Builds RISC-V instruction words from an immediate plus register/opcode
// fields, range-checks the immediate and splits wide ADDI constants into LUI+ADDI.
module imm_encoder (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_out_word;
  logic [31:0] w_out_word_next;
  logic        r_out_err;
  logic        w_out_err_next;
  logic        r_out_last;
  logic        w_out_last_next;
  logic [31:0] r_pend_word;
  logic [31:0] w_pend_word_next;
  logic [15:0] r_err_count;

  logic [31:0] w_imm;
  logic        w_legal;
  logic [31:0] w_enc_word;
  logic        w_split;
  logic [19:0] w_hi;
  logic [31:0] w_lui_word;
  logic [31:0] w_addi_word;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_load;

  assign w_imm = bus.imm;

  always_comb begin
    w_legal    = 1'b0;
    w_enc_word = 32'd0;
    case (bus.imm_src)
      3'b000: begin
        w_legal    = (&w_imm[31:11]) | ~(|w_imm[31:11]);
        w_enc_word = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      end
      3'b001: begin
        w_legal    = (&w_imm[31:11]) | ~(|w_imm[31:11]);
        w_enc_word = {w_imm[11:5], bus.rs2, bus.rs1, bus.funct3, w_imm[4:0], bus.opcode};
      end
      3'b010: begin
        w_legal    = ((&w_imm[31:12]) | ~(|w_imm[31:12])) & ~w_imm[0];
        w_enc_word = {w_imm[12], w_imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      w_imm[4:1], w_imm[11], bus.opcode};
      end
      3'b011: begin
        w_legal    = ((&w_imm[31:20]) | ~(|w_imm[31:20])) & ~w_imm[0];
        w_enc_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd, bus.opcode};
      end
      3'b100: begin
        w_legal    = ~(|w_imm[11:0]);
        w_enc_word = {w_imm[31:12], bus.rd, bus.opcode};
      end
      default: begin
        w_legal    = 1'b0;
        w_enc_word = 32'd0;
      end
    endcase
  end

  // ADDI sign-extends its low 12 bits, so the LUI half absorbs bit 11 as a carry.
  assign w_split = (bus.imm_src == 3'b000) && !w_legal && bus.split_en &&
                   (bus.opcode == 7'b0010011) && (bus.funct3 == 3'b000);
  assign w_hi        = w_imm[31:12] + {19'd0, w_imm[11]};
  assign w_lui_word  = {w_hi, bus.rd, 7'b0110111};
  assign w_addi_word = {w_imm[11:0], bus.rd, 3'b000, bus.rd, 7'b0010011};

  always_comb begin
    w_state_next     = r_state;
    w_out_word_next  = r_out_word;
    w_out_err_next   = r_out_err;
    w_out_last_next  = r_out_last;
    w_pend_word_next = r_pend_word;
    w_in_ready       = 1'b0;
    w_out_valid      = 1'b0;
    w_load           = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_in_ready = 1'b1;
        w_load     = bus.in_valid;
      end
      ST_FULL: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_load = 1'b1;
          end else begin
            w_state_next = ST_EMPTY;
          end
        end
      end
      ST_PEND: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_out_word_next = r_pend_word;
          w_out_err_next  = 1'b0;
          w_out_last_next = 1'b1;
          w_state_next    = ST_FULL;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    if (!rst) begin
      w_in_ready = 1'b0;
    end
    if (w_load) begin
      if (w_split) begin
        w_out_word_next  = w_lui_word;
        w_out_err_next   = 1'b0;
        w_out_last_next  = 1'b0;
        w_pend_word_next = w_addi_word;
        w_state_next     = ST_PEND;
      end else begin
        w_out_word_next = w_enc_word;
        w_out_err_next  = !w_legal;
        w_out_last_next = 1'b1;
        w_state_next    = ST_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_word  <= 32'd0;
      r_out_err   <= 1'b0;
      r_out_last  <= 1'b0;
      r_pend_word <= 32'd0;
      r_err_count <= 16'd0;
    end else begin
      r_out_word  <= w_out_word_next;
      r_out_err   <= w_out_err_next;
      r_out_last  <= w_out_last_next;
      r_pend_word <= w_pend_word_next;
      if (w_out_valid && bus.out_ready && r_out_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_word  = r_out_word;
  assign bus.out_err   = r_out_err;
  assign bus.out_last  = r_out_last;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios plus randomized
// traffic scored against an arithmetic model of the instruction formats.
module tb_imm_encoder;

  typedef struct packed {
    logic [31:0] w;
    logic        e;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imm_encoder_if bus();

  imm_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests  = 0;
  int   n_fail   = 0;
  int   exp_errs = 0;
  exp_t exp_q[$];

  // Model: legality as numeric ranges, fields placed with shifts and masks.
  function automatic void model_push(input logic [2:0] src, input logic [31:0] imm,
                                     input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic se);
    int          v;
    logic        ok;
    logic [31:0] w, d, a, b, op, fn;
    exp_t        t;
    v  = $signed(imm);
    d  = 32'(rd);
    a  = 32'(rs1);
    b  = 32'(rs2);
    op = 32'(opc);
    fn = 32'(f3);
    case (src)
      3'd0: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = ((imm & 32'hFFF) << 20) | (a << 15) | (fn << 12) | (d << 7) | op;
      end
      3'd1: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (fn << 12) |
             ((imm & 32'h1F) << 7) | op;
      end
      3'd2: begin
        ok = (v >= -4096) && (v <= 4094) && ((imm & 32'd1) == 0);
        w  = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20) |
             (a << 15) | (fn << 12) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 32'd1) << 7) | op;
      end
      3'd3: begin
        ok = (v >= -1048576) && (v <= 1048574) && ((imm & 32'd1) == 0);
        w  = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | op;
      end
      3'd4: begin
        ok = ((imm & 32'hFFF) == 0);
        w  = (imm & 32'hFFFFF000) | (d << 7) | op;
      end
      default: begin
        ok = 1'b0;
        w  = 32'd0;
      end
    endcase
    if (src == 3'd0 && !ok && se && opc == 7'h13 && f3 == 3'd0) begin
      t.w = ((imm + 32'h800) & 32'hFFFFF000) | (d << 7) | 32'h37;
      t.e = 1'b0;
      t.l = 1'b0;
      exp_q.push_back(t);
      t.w = ((imm & 32'hFFF) << 20) | (d << 15) | (d << 7) | 32'h13;
      t.l = 1'b1;
      exp_q.push_back(t);
    end else begin
      t.w = w;
      t.e = !ok;
      t.l = 1'b1;
      exp_q.push_back(t);
    end
  endfunction

  function automatic void model_push_bus();
    model_push(bus.imm_src, bus.imm, bus.opcode, bus.funct3, bus.rd, bus.rs1, bus.rs2,
               bus.split_en);
  endfunction

  task automatic set_req(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] opc,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic se);
    bus.imm_src  = src;
    bus.imm      = imm;
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.split_en = se;
  endtask

  task automatic rand_req(input bit allow_split);
    logic [31:0] r;
    logic [31:0] f;
    r = $urandom;
    f = $urandom;
    case ($urandom_range(0, 3))
      0:       bus.imm = r;
      1:       bus.imm = {{20{r[11]}}, r[11:0]};
      2:       bus.imm = {r[31:12], 12'd0};
      default: bus.imm = {{11{r[20]}}, r[20:1], 1'b0};
    endcase
    bus.imm_src  = ($urandom_range(0, 9) == 0) ? 3'(5 + $urandom_range(0, 2))
                                               : 3'($urandom_range(0, 4));
    bus.opcode   = f[6:0];
    bus.funct3   = f[9:7];
    bus.rd       = f[14:10];
    bus.rs1      = f[19:15];
    bus.rs2      = f[24:20];
    bus.split_en = allow_split & f[25];
    if (allow_split && f[27:26] == 2'b00) begin
      bus.imm_src  = 3'd0;
      bus.opcode   = 7'h13;
      bus.funct3   = 3'd0;
      bus.split_en = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_req(3'd0, 32'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if ({bus.out_word, bus.out_err, bus.out_last} !== 34'd0) begin n_fail++; $display("FAIL rst_outputs: got %h/%b/%b want 0/0/0", bus.out_word, bus.out_err, bus.out_last); end
    n_tests++; if (bus.err_count !== 16'd0) begin n_fail++; $display("FAIL rst_err_count: got %0d want 0", bus.err_count); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_i_type();
    @(negedge clk);
    set_req(3'd0, 32'hFFFFFFFF, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL i_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    $display("[TB] I word %h err %b last %b", bus.out_word, bus.out_err, bus.out_last);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL i_valid: got %b want 1", bus.out_valid); end
    n_tests++; if ({bus.out_word, bus.out_err, bus.out_last} !== {32'hFFF30293, 1'b0, 1'b1}) begin n_fail++; $display("FAIL i_word: got %h/%b/%b want fff30293/0/1", bus.out_word, bus.out_err, bus.out_last); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL i_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_b_type();
    @(negedge clk);
    set_req(3'd2, 32'd8, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.imm = 32'd7;
    #1;
    $display("[TB] B word %h err %b", bus.out_word, bus.out_err);
    n_tests++; if ({bus.out_word, bus.out_err} !== {32'h00208463, 1'b0}) begin n_fail++; $display("FAIL b_word: got %h/%b want 00208463/0", bus.out_word, bus.out_err); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    $display("[TB] B odd word %h err %b", bus.out_word, bus.out_err);
    n_tests++; if ({bus.out_word, bus.out_err} !== {32'h00208363, 1'b1}) begin n_fail++; $display("FAIL b_odd: got %h/%b want 00208363/1", bus.out_word, bus.out_err); end
    @(negedge clk);
    #1;
    exp_errs++;
    n_tests++; if (bus.err_count !== 16'(exp_errs)) begin n_fail++; $display("FAIL b_err_count: got %0d want %0d", bus.err_count, exp_errs); end
  endtask

  task automatic test_split();
    @(negedge clk);
    set_req(3'd0, 32'h12345FFF, 7'h13, 3'd0, 5'd10, 5'd0, 5'd0, 1'b1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    set_req(3'd0, 32'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    $display("[TB] split word1 %h last %b", bus.out_word, bus.out_last);
    n_tests++; if ({bus.out_word, bus.out_err, bus.out_last} !== {32'h12346537, 1'b0, 1'b0}) begin n_fail++; $display("FAIL split_w1: got %h/%b/%b want 12346537/0/0", bus.out_word, bus.out_err, bus.out_last); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL split_in_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    #1;
    $display("[TB] split word2 %h last %b", bus.out_word, bus.out_last);
    n_tests++; if ({bus.out_word, bus.out_err, bus.out_last} !== {32'hFFF50513, 1'b0, 1'b1}) begin n_fail++; $display("FAIL split_w2: got %h/%b/%b want fff50513/0/1", bus.out_word, bus.out_err, bus.out_last); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_tests++; if (bus.out_word !== 32'h00100093) begin n_fail++; $display("FAIL split_next: got %h want 00100093", bus.out_word); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL split_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_q.delete();
    @(negedge clk);
    set_req(3'd1, 32'hFFFFFFFC, 7'h23, 3'd2, 5'd0, 5'd3, 5'd4, 1'b0);
    model_push_bus();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    set_req(3'd3, 32'h00000800, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    model_push_bus();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", k, bus.in_ready); end
      n_tests++; if (bus.out_word !== exp_q[0].w) begin n_fail++; $display("FAIL bp_hold: cycle %0d got %h want %h", k, bus.out_word, exp_q[0].w); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    $display("[TB] bp first %h", bus.out_word);
    n_tests++; if ({bus.in_ready, bus.out_word} !== {1'b1, e.w}) begin n_fail++; $display("FAIL bp_first: got %b/%h want 1/%h", bus.in_ready, bus.out_word, e.w); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    $display("[TB] bp second %h", bus.out_word);
    n_tests++; if ({bus.out_valid, bus.out_word, bus.out_err} !== {1'b1, e.w, e.e}) begin n_fail++; $display("FAIL bp_second: got %b/%h/%b want 1/%h/%b", bus.out_valid, bus.out_word, bus.out_err, e.w, e.e); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_u_invalid();
    @(negedge clk);
    set_req(3'd4, 32'h00001001, 7'h37, 3'd0, 5'd3, 5'd0, 5'd0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    set_req(3'd5, 32'h0000ABCD, 7'h13, 3'd0, 5'd3, 5'd4, 5'd5, 1'b0);
    #1;
    $display("[TB] U word %h err %b", bus.out_word, bus.out_err);
    n_tests++; if ({bus.out_word, bus.out_err} !== {32'h000011B7, 1'b1}) begin n_fail++; $display("FAIL u_err: got %h/%b want 000011b7/1", bus.out_word, bus.out_err); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    $display("[TB] invalid-src word %h err %b", bus.out_word, bus.out_err);
    n_tests++; if ({bus.out_word, bus.out_err} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL inv_word: got %h/%b want 0/1", bus.out_word, bus.out_err); end
    n_tests++; if (bus.err_count !== 16'(exp_errs + 1)) begin n_fail++; $display("FAIL u_err_count: got %0d want %0d", bus.err_count, exp_errs + 1); end
    @(negedge clk);
    #1;
    exp_errs += 2;
    n_tests++; if (bus.err_count !== 16'(exp_errs)) begin n_fail++; $display("FAIL inv_err_count: got %0d want %0d", bus.err_count, exp_errs); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (k < 20) begin
        rand_req(1'b0);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", k, bus.in_ready); end
      n_tests++; if (bus.out_valid !== (k > 0)) begin n_fail++; $display("FAIL b2b_valid: cycle %0d got %b want %b", k, bus.out_valid, k > 0); end
      if (k > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++; if ({bus.out_word, bus.out_err, bus.out_last} !== {e.w, e.e, e.l}) begin n_fail++; $display("FAIL b2b_word: cycle %0d got %h/%b/%b want %h/%b/%b", k, bus.out_word, bus.out_err, bus.out_last, e.w, e.e, e.l); end
        if (e.e) exp_errs++;
      end
      if (bus.in_valid) model_push_bus();
    end
    @(negedge clk);
    #1;
    n_tests++; if ({bus.out_valid, bus.err_count} !== {1'b0, 16'(exp_errs)}) begin n_fail++; $display("FAIL b2b_end: got %b/%0d want 0/%0d", bus.out_valid, bus.err_count, exp_errs); end
  endtask

  task automatic test_random();
    exp_t e;
    bit   have;
    have = 1'b0;
    exp_q.delete();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 620; c++) begin
      @(negedge clk);
      if (c >= 600) begin
        bus.in_valid = 1'b0;
        have = 1'b0;
      end else if (!have) begin
        if ($urandom_range(0, 3) != 0) begin
          rand_req(1'b1);
          bus.in_valid = 1'b1;
          have = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = (c >= 600) || ($urandom_range(0, 3) != 0);
      #1;
      n_tests++; if (bus.out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid: cycle %0d got %b want %b", c, bus.out_valid, exp_q.size() != 0); end
      n_tests++; if (bus.err_count !== 16'(exp_errs)) begin n_fail++; $display("FAIL rnd_err_count: cycle %0d got %0d want %0d", c, bus.err_count, exp_errs); end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rnd_extra: cycle %0d got %h want no word", c, bus.out_word);
        end else begin
          e = exp_q.pop_front();
          if (c < 40) $display("[TB] rnd word %h err %b last %b", bus.out_word, bus.out_err, bus.out_last);
          n_tests++; if ({bus.out_word, bus.out_err, bus.out_last} !== {e.w, e.e, e.l}) begin n_fail++; $display("FAIL rnd_word: cycle %0d got %h/%b/%b want %h/%b/%b", c, bus.out_word, bus.out_err, bus.out_last, e.w, e.e, e.l); end
          if (e.e && exp_errs < 65535) exp_errs++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model_push_bus();
        have = 1'b0;
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_lost: got %0d words outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_reset_in_pend();
    exp_t e;
    exp_q.delete();
    @(negedge clk);
    set_req(3'd0, 32'h7FFFF800, 7'h13, 3'd0, 5'd7, 5'd0, 5'd0, 1'b1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_tests++; if ({bus.out_valid, bus.out_last} !== 2'b10) begin n_fail++; $display("FAIL pend_state: got %b/%b want 1/0", bus.out_valid, bus.out_last); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL pend_rst_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    rst = 1'b1;
    exp_errs = 0;
    #1;
    n_tests++; if ({bus.out_valid, bus.err_count, bus.out_word} !== {1'b0, 16'd0, 32'd0}) begin n_fail++; $display("FAIL pend_rst: got %b/%0d/%h want 0/0/0", bus.out_valid, bus.err_count, bus.out_word); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL pend_no_w2: got %b want 0", bus.out_valid); end
    set_req(3'd0, 32'h00000123, 7'h13, 3'd0, 5'd2, 5'd4, 5'd0, 1'b0);
    model_push_bus();
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    $display("[TB] post-reset word %h", bus.out_word);
    n_tests++; if ({bus.out_valid, bus.out_word, bus.out_err, bus.out_last} !== {1'b1, e.w, e.e, e.l}) begin n_fail++; $display("FAIL pend_after: got %b/%h/%b/%b want 1/%h/%b/%b", bus.out_valid, bus.out_word, bus.out_err, bus.out_last, e.w, e.e, e.l); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_b_type();
    test_split();
    test_backpressure();
    test_u_invalid();
    test_back_to_back();
    test_random();
    test_reset_in_pend();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Instruction-word builder: the inverse of the pipeline's immediate extension. It takes a 32-bit immediate, an immediate-type code and register/opcode fields, and range-checks the immediate. It scatters the immediate bits into a RISC-V instruction word and emits the word through a valid/ready output register. It also splits an out-of-range ADDI constant into a LUI+ADDI pair. It is used by the program loader and self-test sequencer to generate instruction memory contents.

## Interface
- No parameters; all widths fixed.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset; sampled on clk rising edge
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid && in_ready
- imm_src  input  3  000 I, 001 S, 010 B, 011 J, 100 U; 101–111 invalid
- imm  input  32  immediate value (two's complement)
- opcode  input  7  instruction [6:0]
- funct3  input  3  instruction [14:12] (ignored for J/U)
- rd, rs1, rs2  input  5 each  register fields (used per type)
- split_en  input  1  permit LUI+ADDI expansion
- out_valid  output  1  out_word valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_word  output  32  encoded instruction
- out_err  output  1  word produced from an illegal request
- out_last  output  1  final word of the current request
- err_count  output  16  saturating count of emitted words with out_err=1

## Operation
- Encodings (i = imm):
  - I: {i[11:0], rs1, funct3, rd, opcode}
  - S: {i[11:5], rs2, rs1, funct3, i[4:0], opcode}
  - B: {i[12], i[10:5], rs2, rs1, funct3, i[4:1], i[11], opcode}
  - J: {i[20], i[10:1], i[11], i[19:12], rd, opcode}
  - U: {i[31:12], rd, opcode}
- Legality:
  - I/S: i[31:11] all equal.
  - B: i[31:12] all equal and i[0]=0.
  - J: i[31:20] all equal and i[0]=0.
  - U: i[11:0]=0.
- Illegal request: the word is still encoded from the truncated bits and out_err=1. For an invalid imm_src, out_word=0 and out_err=1.
- Split: applies when imm_src=I, the immediate is illegal, split_en=1, opcode=0010011 and funct3=000.
  - hi = i[31:12] + i[11], computed mod 2^20.
  - Word 1 = LUI {hi, rd, 0110111}, with out_last=0 and out_err=0.
  - Word 2 = ADDI {i[11:0], rd, 000, rd, 0010011}, with out_last=1 and out_err=0.
  - Both words are always emitted, even when i[11:0]=0.
- All non-split words have out_last=1.
- err_count increments on each output handshake with out_err=1 and saturates at 0xFFFF.
- FSM states:
  - EMPTY: in_ready=1, out_valid=0. An accept moves to FULL, or to PEND for a split.
  - FULL: out_valid=1, in_ready=out_ready.
    - Output handshake with an accept: load the new word and go to FULL or PEND.
    - Output handshake without an accept: go to EMPTY.
    - No handshake: hold.
  - PEND: out_valid=1 with word 1 shown, in_ready=0. On output handshake, load word 2 from the pending register and go to FULL.

## Timing
- Reset (rst=0 at an edge) forces:
  - state EMPTY
  - out_valid=0, out_word=0, out_err=0, out_last=0
  - err_count=0
  - pending register cleared
- in_ready is 0 during the reset cycle.
- Reset in PEND discards word 2.
- Latency: an accept at edge N presents the word with out_valid=1 after edge N.
- Throughput: one word per cycle in the FULL state when out_ready=1 and in_valid=1 hold every cycle. A split costs two output cycles.
- While out_valid=1 and out_ready=0, out_word, out_err and out_last are held stable.
- in_ready depends combinationally on out_ready (FULL) and on state; there is no in_valid→in_ready path.
- Simultaneous output handshake and input accept in FULL replaces the word in the same edge with no bubble.
- Inputs are sampled only at accept; changes while in_ready=0 have no effect.

## Test plan
- I, imm=0xFFFFFFFF, opcode=0x13, funct3=0, rd=5, rs1=6 → out_word 0xFFF30293, out_err 0, out_last 1, out_valid the cycle after accept.
- B, imm=8, opcode=0x63, funct3=0, rs1=1, rs2=2 → 0x00208463. Then imm=7 → out_err 1 and err_count 1.
- Split, imm=0x12345FFF, rd=10, rs1=0, opcode=0x13, funct3=0, split_en=1 → 0x12346537 (last 0), then 0xFFF50513 (last 1). in_ready=0 while word 1 is shown.
- Backpressure: hold out_ready=0 for 3 cycles with a second request pending → out_word unchanged and in_ready 0. After release, both words emerge in order with no loss or duplication.
- U, imm=0x00001001 → out_err 1. Invalid imm_src=101 → out_word 0, out_err 1, err_count +1 each.
- Drive rst=0 for one cycle while in PEND → out_valid 0, err_count 0, no word 2 emitted. The next request encodes normally.
